fb_write_coalescer: RTL and testbench

Framebuffer write stage directly downstream of the rasterizer. It accepts single-pixel writes (`fb_x`, `fb_y`, 4-bit `data`, `fb_we`), buffers them in a FIFO, and merges pixels that fall in the same 16-bit framebuffer word, four 4-bpp pixels per word. It issues nibble-masked word writes to the framebuffer memory port over a req/ack handshake. An optional clear engine fills the whole framebuffer with zero.

---
 rtl/fb_write_coalescer.sv | 145 ++++++++++++++
 tb/tb_fb_write_coalescer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_coalescer.sv
// fb_write_coalescer: merges rasterizer pixel writes into nibble-masked framebuffer word writes (optional clear engine under FB_CLEAR_EN)
module fb_write_coalescer #(
    parameter int FIFO_DEPTH = 16,
    parameter int IDLE_FLUSH = 8,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [9:0]  fb_x,
    input  logic [9:0]  fb_y,
    input  logic [3:0]  data,
    input  logic        fb_we,
    input  logic        flush,
    output logic        fifo_full,
    output logic        busy,
    output logic [15:0] drop_count,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [16:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [3:0]  mem_nmask,
    input  logic        clear_start,
    output logic        clear_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(IDLE_FLUSH + 1);
    localparam logic [1:0] COLLECT = 2'd0, WRITE = 2'd1, CLEAR = 2'd2;

    logic [16:0]   f_addr [FIFO_DEPTH];
    logic [5:0]    f_pix  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [16:0]   m_addr;
    logic [15:0]   m_data;
    logic [3:0]    m_mask;
    logic          m_valid;
    logic [IW-1:0] idle_cnt;
    logic          in_range, push, drop, empty, same, idle_hit, collect, clr_go, load, to_write, fresh;
    logic [16:0]   in_addr, h_addr, clr_addr;
    logic [1:0]    h_nib;
    logic [3:0]    h_dat;
    logic [15:0]   new_data;
    logic [3:0]    new_mask;

    assign in_range  = ({1'b0, fb_x} < 11'(FB_WIDTH)) && ({1'b0, fb_y} < 11'(FB_HEIGHT));
    assign in_addr   = 17'(fb_y) * 17'(FB_WIDTH / 4) + 17'(fb_x[9:2]);
    assign fifo_full = count == CW'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign push      = fb_we && in_range && !fifo_full;
    assign drop      = fb_we && !push;
    assign h_addr    = f_addr[rd_ptr];
    assign {h_nib, h_dat} = f_pix[rd_ptr];
    assign collect   = state == COLLECT;
    assign same      = m_valid && (h_addr == m_addr);
    assign idle_hit  = m_valid && empty && (idle_cnt == IW'(IDLE_FLUSH - 1));
    // A WRITE ack frees the merge register, so the head may load fresh in that same cycle.
    assign load      = collect ? (!clr_go && !empty && (!m_valid || same)) : (state == WRITE && mem_ack && !empty);
    assign to_write  = collect && !clr_go && m_valid && (empty ? (flush || idle_hit) : !same);
    assign fresh     = !collect || !m_valid;
    assign new_data  = (fresh ? 16'h0 : m_data & ~(16'hF << {h_nib, 2'b00})) | (16'(h_dat) << {h_nib, 2'b00});
    assign new_mask  = (fresh ? 4'h0 : m_mask) | (4'b1 << h_nib);

    assign busy      = !empty || m_valid || mem_req || (state != COLLECT);
    assign mem_addr  = !mem_req ? '0 : (state == CLEAR) ? clr_addr : m_addr;
    assign mem_wdata = (mem_req && state != CLEAR) ? m_data : '0;
    assign mem_nmask = !mem_req ? '0 : (state == CLEAR) ? 4'hF : m_mask;

`ifdef FB_CLEAR_EN
    localparam logic [16:0] LAST_ADDR = 17'(FB_WIDTH * FB_HEIGHT / 4 - 1);
    logic clr_pend;
    assign clr_go     = collect && (clr_pend || clear_start) && empty && !m_valid;
    assign clear_busy = state == CLEAR;
    // Clear request latch (held until the pipeline drains) and sweep address.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            clr_pend <= 1'b0;
            clr_addr <= '0;
        end else begin
            clr_pend <= clr_go ? 1'b0 : clr_pend || (clear_start && state != CLEAR);
            clr_addr <= clr_go ? '0 : (state == CLEAR && mem_ack) ? clr_addr + 17'd1 : clr_addr;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = clear_start;
    assign clr_go       = 1'b0;
    assign clear_busy   = 1'b0;
    assign clr_addr     = '0;
`endif

    // Pixel FIFO storage; occupancy is tracked by count so entries need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wr_ptr] <= in_addr;
            f_pix[wr_ptr]  <= {fb_x[1:0], data};
        end
    end

    // FIFO pointers, drop counter, merge register, idle timer and FSM.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            m_addr     <= '0;
            m_data     <= '0;
            m_mask     <= '0;
            m_valid    <= 1'b0;
            idle_cnt   <= '0;
            state      <= COLLECT;
            mem_req    <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(load);
            count      <= count + CW'(push) - CW'(load);
            drop_count <= (drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
            idle_cnt   <= (collect && m_valid && empty && !to_write) ? idle_cnt + IW'(1) : '0;
            if (load) begin
                m_addr  <= h_addr;
                m_data  <= new_data;
                m_mask  <= new_mask;
                m_valid <= 1'b1;
            end else if (state == WRITE && mem_ack) begin
                m_valid <= 1'b0;
            end
            if (to_write || clr_go) begin
                state   <= clr_go ? CLEAR : WRITE;
                mem_req <= 1'b1;
            end else if (state == WRITE && mem_ack) begin
                state   <= COLLECT;
                mem_req <= 1'b0;
            end
`ifdef FB_CLEAR_EN
            else if (state == CLEAR && mem_ack && clr_addr == LAST_ADDR) begin
                state   <= COLLECT;
                mem_req <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fb_write_coalescer.sv
// tb_fb_write_coalescer: directed, table-driven checks of pixel merging, drops, flushes and clear
module tb_fb_write_coalescer;
    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [9:0]  fb_x = '0, fb_y = '0;
    logic [3:0]  data = '0;
    logic        fb_we = 1'b0, flush = 1'b0, mem_ack = 1'b1, clear_start = 1'b0;
    logic        fifo_full, busy, mem_req, clear_busy;
    logic [15:0] drop_count, mem_wdata;
    logic [16:0] mem_addr;
    logic [3:0]  mem_nmask;

    fb_write_coalescer dut (
        .clk(clk), .areset(areset), .fb_x(fb_x), .fb_y(fb_y), .data(data), .fb_we(fb_we),
        .flush(flush), .fifo_full(fifo_full), .busy(busy), .drop_count(drop_count),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_nmask(mem_nmask), .clear_start(clear_start), .clear_busy(clear_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x, y;
        logic [3:0]  d;
        logic        drop;
        logic [16:0] addr;
        logic [15:0] wd;
        logic [3:0]  nm;
    } vec_t;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, wr_n = 0, cl_n = 0, cl_bad = 0, exp_drop = 0;
    logic clr_mode = 1'b0;
    logic [16:0] lg_addr [64];
    logic [15:0] lg_data [64];
    logic [3:0]  lg_mask [64];
    int          lg_cyc  [64];
    vec_t tbl [7];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every accepted write, sampled mid-cycle before the completing edge.
    always @(negedge clk) begin
        if (!areset && mem_req && mem_ack) begin
            if (clr_mode) begin
                if (mem_addr != 17'(cl_n) || mem_wdata != 16'h0 || mem_nmask != 4'hF) cl_bad++;
                cl_n++;
            end else begin
                if (wr_n < 64) begin
                    lg_addr[wr_n] = mem_addr;
                    lg_data[wr_n] = mem_wdata;
                    lg_mask[wr_n] = mem_nmask;
                    lg_cyc[wr_n]  = cyc;
                end
                wr_n++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [3:0] d);
        fb_x = x; fb_y = y; data = d; fb_we = 1'b1;
        step(1);
        fb_we = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    task automatic wait_wr(input string nm, input int target, input int budget);
        int k = 0;
        while (wr_n < target && k < budget) begin
            step(1);
            k++;
        end
        chk(nm, 32'(wr_n), 32'(target));
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic chk_wr(input string nm, input int i, input logic [16:0] a, input logic [15:0] d, input logic [3:0] m);
        chk({nm, " addr"}, 32'(lg_addr[i]), 32'(a));
        chk({nm, " wdata"}, 32'(lg_data[i]), 32'(d));
        chk({nm, " nmask"}, 32'(lg_mask[i]), 32'(m));
    endtask

    initial begin
        int b;
        tbl[0] = '{10'd0,   10'd0,    4'h3, 1'b0, 17'd0,     16'h0003, 4'b0001};
        tbl[1] = '{10'd639, 10'd479,  4'hA, 1'b0, 17'd76799, 16'hA000, 4'b1000};
        tbl[2] = '{10'd5,   10'd1,    4'h7, 1'b0, 17'd161,   16'h0070, 4'b0010};
        tbl[3] = '{10'd2,   10'd300,  4'hF, 1'b0, 17'd48000, 16'h0F00, 4'b0100};
        tbl[4] = '{10'd640, 10'd0,    4'h1, 1'b1, 17'd0,     16'h0000, 4'b0000};
        tbl[5] = '{10'd0,   10'd480,  4'h2, 1'b1, 17'd0,     16'h0000, 4'b0000};
        tbl[6] = '{10'd1023,10'd1023, 4'h3, 1'b1, 17'd0,     16'h0000, 4'b0000};

        step(3);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
        chk("reset mem_nmask", 32'(mem_nmask), 32'd0);
        chk("reset busy/full/clear_busy", {29'd0, busy, fifo_full, clear_busy}, 32'd0);
        chk("reset drop_count", 32'(drop_count), 32'd0);
        areset = 1'b0;
        step(2);

        // Four pixels of one word merge into a single full write.
        b = wr_n;
        for (int i = 0; i < 4; i++) pix(10'(4 + i), 10'd10, 4'(i + 1));
        wait_wr("four-pixel write count", b + 1, 40);
        chk_wr("four-pixel", b, 17'd1601, 16'h4321, 4'b1111);
        wait_idle("idle after four-pixel", 50);

        // Serpentine: word change forces a write, then idle flush of the remainder.
        b = wr_n;
        pix(10'd7, 10'd0, 4'd5);
        pix(10'd6, 10'd0, 4'd6);
        pix(10'd5, 10'd0, 4'd7);
        pix(10'd3, 10'd0, 4'd8);
        wait_wr("serpentine write count", b + 2, 40);
        chk_wr("serpentine first", b, 17'd1, 16'h5670, 4'b1110);
        chk_wr("serpentine second", b + 1, 17'd0, 16'h8000, 4'b1000);
        chk("serpentine idle flush gap", 32'(lg_cyc[b + 1] - lg_cyc[b]), 32'd9);
        wait_idle("idle after serpentine", 50);

        // Duplicate nibble with explicit flush: later pixel wins, write follows flush promptly.
        b = wr_n;
        pix(10'd0, 10'd0, 4'd3);
        pix(10'd0, 10'd0, 4'd9);
        step(1);
        pulse_flush();
        wait_wr("flush write promptness", b + 1, 2);
        wait_wr("flush write count", b + 1, 20);
        chk_wr("same nibble", b, 17'd0, 16'h0009, 4'b0001);
        wait_idle("idle after flush", 50);

        // Table of single pixels: mapping checks and range drops.
        for (int i = 0; i < 7; i++) begin
            b = wr_n;
            pix(tbl[i].x, tbl[i].y, tbl[i].d);
            step(2);
            pulse_flush();
            if (tbl[i].drop) begin
                exp_drop++;
                step(12);
                chk($sformatf("vec%0d no write", i), 32'(wr_n), 32'(b));
            end else begin
                wait_wr($sformatf("vec%0d write count", i), b + 1, 20);
                chk_wr($sformatf("vec%0d", i), b, tbl[i].addr, tbl[i].wd, tbl[i].nm);
            end
            chk($sformatf("vec%0d drop_count", i), 32'(drop_count), 32'(exp_drop));
            wait_idle($sformatf("vec%0d idle", i), 50);
        end

        // Stall: 30 distinct-word pixels against a held-off ack.
        b = wr_n;
        mem_ack = 1'b0;
        for (int i = 0; i < 30; i++) pix(10'(4 * i), 10'd2, 4'(i));
        step(10);
        exp_drop += 13;
        chk("stall drop_count", 32'(drop_count), 32'(exp_drop));
        chk("stall fifo_full", 32'(fifo_full), 32'd1);
        chk("stall mem_req held", 32'(mem_req), 32'd1);
        chk("stall no writes", 32'(wr_n), 32'(b));
        mem_ack = 1'b1;
        wait_wr("stall drain count", b + 17, 300);
        for (int i = 0; i < 17; i++) chk_wr($sformatf("stall w%0d", i), b + i, 17'(320 + i), 16'(i % 16), 4'b0001);
        wait_idle("idle after stall", 50);

        // Asynchronous reset abandons an in-flight write.
        mem_ack = 1'b0;
        pix(10'd8, 10'd8, 4'd1);
        step(1);
        pulse_flush();
        begin
            int k = 0;
            while (!mem_req && k < 10) begin
                step(1);
                k++;
            end
        end
        chk("pre-reset mem_req", 32'(mem_req), 32'd1);
        #2 areset = 1'b1;
        #1;
        chk("async reset mem_req", 32'(mem_req), 32'd0);
        chk("async reset outputs", {drop_count, 12'd0, busy, fifo_full, clear_busy, 1'b0}, 32'd0);
        @(posedge clk);
        #1 areset = 1'b0;
        mem_ack = 1'b1;
        exp_drop = 0;
        step(2);

`ifdef FB_CLEAR_EN
        // Full framebuffer clear with ack always high.
        clr_mode = 1'b1;
        cl_n = 0;
        cl_bad = 0;
        clear_start = 1'b1;
        step(1);
        clear_start = 1'b0;
        chk("clear_busy rises", 32'(clear_busy), 32'd1);
        begin
            int k = 0;
            while (clear_busy && k < 80000) begin
                step(1);
                k++;
            end
        end
        chk("clear_busy falls", 32'(clear_busy), 32'd0);
        chk("clear write count", 32'(cl_n), 32'd76800);
        chk("clear bad writes", 32'(cl_bad), 32'd0);
        chk("clear mem_req done", 32'(mem_req), 32'd0);
        // Reset mid-clear.
        clear_start = 1'b1;
        step(1);
        clear_start = 1'b0;
        step(100);
        chk("mid-clear busy", 32'(clear_busy), 32'd1);
        #2 areset = 1'b1;
        #1;
        chk("mid-clear reset outputs", {mem_addr, mem_nmask, 8'd0, mem_req, clear_busy, busy}, 32'd0);
        @(posedge clk);
        #1 areset = 1'b0;
        clr_mode = 1'b0;
        step(2);
`else
        // Without the clear engine, clear_start does nothing.
        b = wr_n;
        clear_start = 1'b1;
        step(1);
        clear_start = 1'b0;
        step(20);
        chk("clear disabled clear_busy", 32'(clear_busy), 32'd0);
        chk("clear disabled no writes", 32'(wr_n), 32'(b));
        chk("clear disabled busy", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
